hud_stats_display: RTL and testbench

- Parametrised multi-channel statistics HUD for the 1024x768 65 MHz video path.
- Holds one saturating BCD hit counter per tracked blob/drum channel, updated by write commands.
- Renders every counter as a row of 7-segment digits at a fixed screen origin, with a timed colour flash when a channel increments.
- Merges the digits onto a supplied background pixel through a 2-stage pipeline with selectable blend mode.

---
 rtl/hud_stats_display.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_hud_stats_display.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hud_stats_display.sv
// hud_stats_display
//   Statistics overlay for the 1024x768 / 65 MHz video path. Keeps one
//   saturating BCD hit counter per channel and draws each counter as a row of
//   7-segment glyphs at a fixed screen origin. A channel flashes in FLASH_COLOR
//   for FLASH_FRAMES frames after every increment. The glyphs are merged onto
//   the incoming background pixel through a 2-stage pipeline.
//
// Ports
//   vclock    : pixel clock
//   reset     : asynchronous, active-low reset
//   write     : command strobe (one cycle)
//   op        : 00 LOAD, 01 INC, 10 CLEAR, 11 CLEAR_ALL
//   num       : LOAD value (clamped to 9, placed in the units digit)
//   blob      : target channel; values >= NUM_CH are ignored
//   blend     : 00 OR, 01 overwrite, 10 half-blend, 11 HUD off
//   hcount    : pixel column
//   vcount    : line
//   bg_pixel  : background pixel {r,g,b}
//   hud_pixel : merged pixel, 2 cycles after hcount/vcount/bg_pixel
module hud_stats_display #(
  parameter int          NUM_CH       = 4,
  parameter int          DIGITS       = 3,
  parameter int          X0           = 512,
  parameter int          Y0           = 0,
  parameter int          SCALE        = 2,
  parameter int          ROW_GAP      = 4,
  parameter int          FLASH_FRAMES = 30,
  parameter logic [23:0] COLOR        = 24'hFFFFFF,
  parameter logic [23:0] FLASH_COLOR  = 24'hFF0000
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        write,
  input  logic [1:0]  op,
  input  logic [3:0]  num,
  input  logic [3:0]  blob,
  input  logic [1:0]  blend,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [23:0] bg_pixel,
  output logic [23:0] hud_pixel
);

  localparam int CELL_W = 8 * SCALE;
  localparam int CELL_H = 16 * SCALE;
  localparam int PITCH  = CELL_H + ROW_GAP;
  localparam int CW     = 4 * DIGITS;
  localparam int FW     = $clog2(FLASH_FRAMES + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [1:0] BL_OR    = 2'b00;
  localparam logic [1:0] BL_OVW   = 2'b01;
  localparam logic [1:0] BL_HALF  = 2'b10;

  // ---------------------------------------------------------------------------
  // Counters and flash timers. Counter is packed BCD, units digit in [3:0].
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_reg   [NUM_CH];
  logic [CW-1:0] cnt_next  [NUM_CH];
  logic [FW-1:0] flash_reg [NUM_CH];
  logic [FW-1:0] flash_next[NUM_CH];

  logic       frame_tick;
  logic [3:0] load_val;

  assign frame_tick = (hcount == 11'd0) && (vcount == 10'd0);
  assign load_val   = (num > 4'd9) ? 4'd9 : num;

  // Decimal +1 with saturation at all nines.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    if (v != {DIGITS{4'h9}}) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_next[i]   = cnt_reg[i];
      flash_next[i] = flash_reg[i];
      if (frame_tick && (flash_reg[i] != '0))
        flash_next[i] = flash_reg[i] - FW'(1);
      // Commands are evaluated after the tick so an INC reload overrides the
      // decrement of the same cycle.
      if (write) begin
        case (op)
          OP_LOAD: begin
            if (blob == 4'(i)) cnt_next[i] = CW'(load_val);
          end
          OP_INC: begin
            if (blob == 4'(i)) begin
              cnt_next[i]   = bcd_inc(cnt_reg[i]);
              flash_next[i] = FW'(FLASH_FRAMES);
            end
          end
          OP_CLEAR: begin
            if (blob == 4'(i)) begin
              cnt_next[i]   = '0;
              flash_next[i] = '0;
            end
          end
          default: begin
            cnt_next[i]   = '0;
            flash_next[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_reg[i]   <= '0;
        flash_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_reg[i]   <= cnt_next[i];
        flash_reg[i] <= flash_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: locate the cell under the beam and fetch its digit.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] row_hit;
  logic [DIGITS-1:0] col_hit;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_row
    assign row_hit[gi] = (int'(vcount) >= Y0 + gi * PITCH) &&
                         (int'(vcount) <  Y0 + gi * PITCH + CELL_H);
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_col
    assign col_hit[gi] = (int'(hcount) >= X0 + gi * CELL_W) &&
                         (int'(hcount) <  X0 + gi * CELL_W + CELL_W);
  end

  logic [CH_W-1:0] ch_c;
  logic [CW-1:0]   sel_cnt;
  logic [3:0]      digit_c;
  logic            blank_c;
  logic            hit_c;
  logic [2:0]      gx_c;
  logic [3:0]      gy_c;
  int              row_base;
  int              col_base;

  always_comb begin
    ch_c     = '0;
    sel_cnt  = '0;
    digit_c  = '0;
    blank_c  = 1'b0;
    row_base = Y0;
    col_base = X0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (row_hit[i]) begin
        ch_c     = CH_W'(i);
        sel_cnt  = cnt_reg[i];
        row_base = Y0 + i * PITCH;
      end
    end
    for (int j = 0; j < DIGITS; j++) begin
      if (col_hit[j]) begin
        col_base = X0 + j * CELL_W;
        digit_c  = sel_cnt[(DIGITS-1-j)*4 +: 4];
        // Leading zero: this digit and everything more significant is zero.
        blank_c  = (j != DIGITS - 1) && ((sel_cnt >> ((DIGITS-1-j)*4)) == '0);
      end
    end
    hit_c = (|row_hit) && (|col_hit) && !blank_c;
    gx_c  = 3'((int'(hcount) - col_base) / SCALE);
    gy_c  = 4'((int'(vcount) - row_base) / SCALE);
  end

  logic            s1_hit_reg;
  logic [CH_W-1:0] s1_ch_reg;
  logic [3:0]      s1_digit_reg;
  logic [2:0]      s1_gx_reg;
  logic [3:0]      s1_gy_reg;
  logic [23:0]     s1_bg_reg;
  logic [1:0]      s1_blend_reg;

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      s1_hit_reg   <= 1'b0;
      s1_ch_reg    <= '0;
      s1_digit_reg <= '0;
      s1_gx_reg    <= '0;
      s1_gy_reg    <= '0;
      s1_bg_reg    <= '0;
      s1_blend_reg <= '0;
    end else begin
      s1_hit_reg   <= hit_c;
      s1_ch_reg    <= ch_c;
      s1_digit_reg <= digit_c;
      s1_gx_reg    <= gx_c;
      s1_gy_reg    <= gy_c;
      s1_bg_reg    <= bg_pixel;
      s1_blend_reg <= blend;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: glyph rasterisation, colour select and blend.
  // ---------------------------------------------------------------------------
  // Segment bits {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [7:0] half8(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a[7:1]} + {1'b0, b[7:1]};
  endfunction

  logic [6:0]  segs;
  logic        mid_x, left_x, right_x, upper_y, lower_y;
  logic        lit;
  logic        flash_on;
  logic [23:0] digit_color;
  logic [23:0] blended;
  logic [23:0] pix_next;

  always_comb begin
    segs    = seg7(s1_digit_reg);
    mid_x   = (s1_gx_reg >= 3'd1) && (s1_gx_reg <= 3'd6);
    left_x  = (s1_gx_reg <= 3'd1);
    right_x = (s1_gx_reg >= 3'd6);
    upper_y = (s1_gy_reg >= 4'd1) && (s1_gy_reg <= 4'd7);
    lower_y = (s1_gy_reg >= 4'd8) && (s1_gy_reg <= 4'd14);
    lit = s1_hit_reg && (
          (segs[6] && mid_x && (s1_gy_reg <= 4'd1))                         ||
          (segs[5] && right_x && upper_y)                                   ||
          (segs[4] && right_x && lower_y)                                   ||
          (segs[3] && mid_x && (s1_gy_reg >= 4'd14))                        ||
          (segs[2] && left_x && lower_y)                                    ||
          (segs[1] && left_x && upper_y)                                    ||
          (segs[0] && mid_x && ((s1_gy_reg == 4'd7) || (s1_gy_reg == 4'd8))));

    flash_on = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((s1_ch_reg == CH_W'(i)) && (flash_reg[i] != '0)) flash_on = 1'b1;
    end
    digit_color = flash_on ? FLASH_COLOR : COLOR;

    case (s1_blend_reg)
      BL_OR:   blended = digit_color | s1_bg_reg;
      BL_OVW:  blended = digit_color;
      BL_HALF: blended = {half8(digit_color[23:16], s1_bg_reg[23:16]),
                          half8(digit_color[15:8],  s1_bg_reg[15:8]),
                          half8(digit_color[7:0],   s1_bg_reg[7:0])};
      default: blended = s1_bg_reg;
    endcase

    pix_next = lit ? blended : s1_bg_reg;
  end

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) hud_pixel <= 24'h0;
    else        hud_pixel <= pix_next;
  end

endmodule

// File: tb/tb_hud_stats_display.sv
module tb_hud_stats_display;

  logic        vclock = 1'b0;
  logic        reset  = 1'b0;
  logic        write  = 1'b0;
  logic [1:0]  op     = 2'b00;
  logic [3:0]  num    = 4'd0;
  logic [3:0]  blob   = 4'd0;
  logic [1:0]  blend  = 2'b01;
  logic [10:0] hcount = 11'd100;
  logic [9:0]  vcount = 10'd700;
  logic [23:0] bg_pixel = 24'h0;
  logic [23:0] hud_pixel;

  localparam logic [23:0] COL   = 24'hFFFFFF;
  localparam logic [23:0] FLASH = 24'hFF0000;
  localparam logic [23:0] BG    = 24'h010203;
  localparam int BLANK = 10;

  hud_stats_display dut (
    .vclock(vclock), .reset(reset), .write(write), .op(op), .num(num),
    .blob(blob), .blend(blend), .hcount(hcount), .vcount(vcount),
    .bg_pixel(bg_pixel), .hud_pixel(hud_pixel)
  );

  always #5 vclock = ~vclock;

  int cyc = 0;
  always @(posedge vclock) cyc <= cyc + 1;

  // Scoreboard: target cycle, expected pixel, tag.
  int          q_cyc[$];
  logic [23:0] q_exp[$];
  string       q_tag[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push(input int tgt, input logic [23:0] exp, input string tag);
    q_cyc.push_back(tgt);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  // Monitor: compares hud_pixel on the falling edge of each expected cycle.
  always @(negedge vclock) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      n_checks++;
      if (q_cyc[0] < cyc) begin
        n_fail++;
        $display("FAIL %s: slot cycle %0d missed (now %0d)", q_tag[0], q_cyc[0], cyc);
      end else if (hud_pixel !== q_exp[0]) begin
        n_fail++;
        $display("FAIL %s: hud_pixel=%06h expected %06h", q_tag[0], hud_pixel, q_exp[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_exp.pop_front());
      void'(q_tag.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge vclock);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; hcount = 11'd100; vcount = 10'd700; bg_pixel = 24'h0; blend = 2'b01;
  endtask

  task automatic flush();
    idle();
    repeat (3) step();
  endtask

  task automatic cmd(input logic [1:0] o, input logic [3:0] b, input logic [3:0] n);
    write = 1'b1; op = o; blob = b; num = n;
    step();
    write = 1'b0;
  endtask

  task automatic tick();
    hcount = 11'd0; vcount = 10'd0;
    step();
    hcount = 11'd100; vcount = 10'd700;
  endtask

  task automatic pix(input int h, input int v, input logic [23:0] bg, input logic [1:0] bl,
                     input logic [23:0] exp, input string tag);
    hcount = 11'(h); vcount = 10'(v); bg_pixel = bg; blend = bl;
    push(cyc + 2, exp, tag);
    step();
  endtask

  // Standard 7-segment table {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_tab(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Probe the centre of each segment (a..g) plus one always-dark point.
  task automatic check_digit(input int c, input int d, input int dig,
                             input logic [23:0] color, input string tag);
    int gx, gy;
    logic [6:0] s;
    logic on;
    s = seg_tab(dig);
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin gx = 3; gy = 0;  end
        1: begin gx = 7; gy = 4;  end
        2: begin gx = 7; gy = 11; end
        3: begin gx = 3; gy = 15; end
        4: begin gx = 0; gy = 11; end
        5: begin gx = 0; gy = 4;  end
        6: begin gx = 3; gy = 7;  end
        default: begin gx = 3; gy = 4; end
      endcase
      on = (k < 7) && (dig != BLANK) && s[6-k];
      pix(512 + 16*d + 2*gx, 36*c + 2*gy, BG, 2'b01, on ? color : BG,
          $sformatf("%s c%0d d%0d k%0d", tag, c, d, k));
    end
  endtask

  initial begin
    // Reset: output held at zero even with a background present.
    idle();
    bg_pixel = 24'hABCDEF;
    repeat (2) step();
    push(cyc, 24'h0, "in_reset");
    step();
    reset = 1'b1;
    push(cyc,     24'h0,      "post_rst_0");
    push(cyc + 1, 24'h0,      "post_rst_1");
    push(cyc + 2, 24'hABCDEF, "post_rst_lat");
    step();
    step();
    flush();

    // Every row shows a lone "0".
    for (int c = 0; c < 4; c++) begin
      check_digit(c, 0, BLANK, COL, "init");
      check_digit(c, 1, BLANK, COL, "init");
      check_digit(c, 2, 0,     COL, "init");
    end
    flush();

    // 105 increments on channel 1.
    repeat (105) cmd(2'b01, 4'd1, 4'd0);
    check_digit(1, 0, 1, FLASH, "c1_105");
    check_digit(1, 1, 0, FLASH, "c1_105");
    check_digit(1, 2, 5, FLASH, "c1_105");
    flush();

    // 1000 increments on channel 2 saturate at 999.
    repeat (1000) cmd(2'b01, 4'd2, 4'd0);
    for (int d = 0; d < 3; d++) check_digit(2, d, 9, FLASH, "c2_sat");
    flush();

    // Flash lasts exactly 30 frames.
    cmd(2'b01, 4'd0, 4'd0);
    repeat (29) tick();
    check_digit(0, 2, 1, FLASH, "fl_29");
    flush();
    tick();
    check_digit(0, 2, 1, COL, "fl_30");
    check_digit(1, 2, 5, COL, "c1_done");
    flush();

    // INC coinciding with a tick reloads to the full 30.
    cmd(2'b01, 4'd0, 4'd0);
    repeat (5) tick();
    hcount = 11'd0; vcount = 10'd0;
    cmd(2'b01, 4'd0, 4'd0);
    hcount = 11'd100; vcount = 10'd700;
    repeat (29) tick();
    check_digit(0, 2, 3, FLASH, "coin_29");
    flush();
    tick();
    check_digit(0, 2, 3, COL, "coin_30");
    flush();

    // LOAD clamps to 9; out-of-range blob is ignored.
    cmd(2'b00, 4'd3, 4'd13);
    check_digit(3, 0, BLANK, COL, "load9");
    check_digit(3, 2, 9,     COL, "load9");
    flush();
    cmd(2'b00, 4'd7, 4'd5);
    check_digit(3, 2, 9, COL, "blob7");
    check_digit(1, 0, 1, COL, "blob7");
    check_digit(1, 1, 0, COL, "blob7");
    check_digit(1, 2, 5, COL, "blob7");
    check_digit(0, 2, 3, COL, "blob7");
    flush();

    // CLEAR one channel, then CLEAR_ALL while channel 2 is flashing.
    cmd(2'b10, 4'd1, 4'd0);
    check_digit(1, 0, BLANK, COL, "clear");
    check_digit(1, 2, 0,     COL, "clear");
    flush();
    cmd(2'b01, 4'd2, 4'd0);
    cmd(2'b11, 4'd5, 4'd0);
    for (int c = 0; c < 4; c++) begin
      check_digit(c, 1, BLANK, COL, "clr_all");
      check_digit(c, 2, 0,     COL, "clr_all");
    end
    check_digit(2, 0, BLANK, COL, "clr_all");
    flush();

    // Blend modes on a lit pixel (digit 8, segment a), back to back.
    cmd(2'b00, 4'd0, 4'd8);
    pix(550, 0, 24'h204080, 2'b00, 24'hFFFFFF, "bl_or");
    pix(550, 0, 24'h204080, 2'b10, 24'h8F9FBF, "bl_half");
    pix(550, 0, 24'h204080, 2'b11, 24'h204080, "bl_off");
    pix(550, 0, 24'h204080, 2'b01, 24'hFFFFFF, "bl_ovw");
    pix(550, 8, 24'h204080, 2'b00, 24'h204080, "unlit_or");
    pix(550, 8, 24'h204080, 2'b10, 24'h204080, "unlit_half");
    pix(100, 700, 24'h204080, 2'b01, 24'h204080, "outside");
    pix(550, 32, 24'h204080, 2'b01, 24'h204080, "row_gap");
    pix(560, 0, 24'h204080, 2'b01, 24'h204080, "right_edge");
    pix(550, 139, 24'h204080, 2'b01, 24'hFFFFFF, "c3_last_line");
    pix(550, 140, 24'h204080, 2'b01, 24'h204080, "c3_below");
    flush();

    // Asynchronous reset mid-frame with channel 0 showing "7".
    cmd(2'b00, 4'd0, 4'd7);
    hcount = 11'd550; vcount = 10'd0; blend = 2'b01; bg_pixel = 24'h0;
    repeat (3) step();
    push(cyc, 24'hFFFFFF, "pre_rst");
    step();
    #1;
    reset = 1'b0;
    push(cyc, 24'h0, "rst_async");
    step();
    push(cyc, 24'h0, "rst_hold");
    step();
    reset = 1'b1;
    flush();
    check_digit(0, 0, BLANK, COL, "after_rst");
    check_digit(0, 2, 0,     COL, "after_rst");
    flush();

    repeat (5) step();
    if (q_cyc.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q_cyc.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
